mat_addr_gen: RTL and testbench

Parametrised address sequencer for the matrix-multiply datapath. It computes C[M][N] = A[M][K] × B[K][N] and, per start request, walks the full (m, n, k) loop nest. Each beat presents the A read address, the B read address, the C write address and accumulator first/last flags. It generalises the fixed 8×64 row/column sweep to arbitrary dimensions, and adds a start/done handshake, a stall input and accumulator control.

---
 rtl/mat_pkg.sv | 18 +
 rtl/mat_loop_cnt.sv | 41 ++++
 rtl/mat_addr_gen.sv | 168 ++++++++++++++++
 tb/tb_mat_addr_gen.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_pkg.sv
// Shared types and default dimensions for the matrix-multiply address sequencer.
package mat_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int MAT_M = 8;
   localparam int MAT_N = 8;
   localparam int MAT_K = 8;

   // Counter width that stays legal for a degenerate dimension of 1.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mat_loop_cnt.sv
// Wrap counter for one level of the (m, n, k) loop nest; wrap fires on the
// enabled step that returns the count to zero.
module mat_loop_cnt
   import mat_pkg::*;
#(
   parameter int MAX = 8,
   parameter int W   = cnt_w(MAX)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   output logic [W-1:0] cnt,
   output logic         wrap
);

   localparam logic [W-1:0] LAST = W'(MAX - 1);

   logic [W-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign wrap = en && (cnt_q == LAST);

endmodule

// File: rtl/mat_addr_gen.sv
// Address sequencer walking C[M][N] = A[M][K] x B[K][N], k innermost.
// MAT_AGEN_TRANSPOSE_B_EN adds trans_b for column-major B addressing.
module mat_addr_gen
   import mat_pkg::*;
#(
   parameter int M    = MAT_M,
   parameter int N    = MAT_N,
   parameter int K    = MAT_K,
   parameter int AW_A = $clog2(M*K),
   parameter int AW_B = $clog2(K*N),
   parameter int AW_C = $clog2(M*N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            stall,
`ifdef MAT_AGEN_TRANSPOSE_B_EN
   input  logic            trans_b,
`endif
   output logic            busy,
   output logic            valid,
   output logic [AW_A-1:0] addr_a,
   output logic [AW_B-1:0] addr_b,
   output logic [AW_C-1:0] addr_c,
   output logic            acc_first,
   output logic            acc_last,
   output logic            done
);

   localparam int KW = cnt_w(K);
   localparam int NW = cnt_w(N);
   localparam int MW = cnt_w(M);
   localparam logic [KW-1:0]   K_LAST = KW'(K - 1);
   localparam logic [NW-1:0]   N_LAST = NW'(N - 1);
   localparam logic [MW-1:0]   M_LAST = MW'(M - 1);
   localparam logic [AW_A-1:0] A_ROW  = AW_A'(K);

   state_t state_d, state_q;
   logic   run, launch, accept, done_d, done_q;
   logic   k_wrap, n_wrap, m_wrap;
   logic [KW-1:0] k_cnt;
   logic [NW-1:0] n_cnt;
   logic [MW-1:0] m_cnt;

   logic [AW_A-1:0] a_d, a_q, a_base_d, a_base_q;
   logic [AW_B-1:0] b_d, b_q, b_base_d, b_base_q, b_kstep, b_nstep;
   logic [AW_C-1:0] c_d, c_q;

   assign run    = (state_q == RUN);
   assign launch = (state_q == IDLE) && start;
   assign accept = run && !stall;

   mat_loop_cnt #(.MAX(K), .W(KW)) u_k_cnt (
      .clk(clk), .rst(rst), .en(accept), .clr(launch), .cnt(k_cnt), .wrap(k_wrap)
   );
   mat_loop_cnt #(.MAX(N), .W(NW)) u_n_cnt (
      .clk(clk), .rst(rst), .en(k_wrap), .clr(launch), .cnt(n_cnt), .wrap(n_wrap)
   );
   mat_loop_cnt #(.MAX(M), .W(MW)) u_m_cnt (
      .clk(clk), .rst(rst), .en(n_wrap), .clr(launch), .cnt(m_cnt), .wrap(m_wrap)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)  state_d = RUN;
         RUN:     if (m_wrap) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign done_d = accept && (k_cnt == K_LAST) && (n_cnt == N_LAST) && (m_cnt == M_LAST);

`ifdef MAT_AGEN_TRANSPOSE_B_EN
   logic trans_d, trans_q;

   always_comb begin
      trans_d = trans_q;
      if (launch) trans_d = trans_b;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         trans_q <= 1'b0;
      end else begin
         trans_q <= trans_d;
      end
   end

   // Column-major B walks k contiguously and steps a whole column per n.
   assign b_kstep = trans_q ? AW_B'(1) : AW_B'(N);
   assign b_nstep = trans_q ? AW_B'(K) : AW_B'(1);
`else
   assign b_kstep = AW_B'(N);
   assign b_nstep = AW_B'(1);
`endif

   // Incremental address accumulators; bases hold the row start of A and column start of B.
   always_comb begin
      a_d      = a_q;
      a_base_d = a_base_q;
      b_d      = b_q;
      b_base_d = b_base_q;
      c_d      = c_q;
      if (launch) begin
         a_d      = '0;
         a_base_d = '0;
         b_d      = '0;
         b_base_d = '0;
         c_d      = '0;
      end else if (accept) begin
         if (!k_wrap) begin
            a_d = a_q + AW_A'(1);
            b_d = b_q + b_kstep;
         end else if (!n_wrap) begin
            a_d      = a_base_q;
            b_base_d = b_base_q + b_nstep;
            b_d      = b_base_q + b_nstep;
            c_d      = c_q + AW_C'(1);
         end else if (!m_wrap) begin
            a_base_d = a_base_q + A_ROW;
            a_d      = a_base_q + A_ROW;
            b_base_d = '0;
            b_d      = '0;
            c_d      = c_q + AW_C'(1);
         end else begin
            a_d      = '0;
            a_base_d = '0;
            b_d      = '0;
            b_base_d = '0;
            c_d      = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      a_q      <= a_d;
      a_base_q <= a_base_d;
      b_q      <= b_d;
      b_base_q <= b_base_d;
      c_q      <= c_d;
   end

   // Outputs are forced to zero outside RUN so IDLE and reset present a clean bus.
   always_comb begin
      busy      = run;
      valid     = run;
      addr_a    = run ? a_q : '0;
      addr_b    = run ? b_q : '0;
      addr_c    = run ? c_q : '0;
      acc_first = run && (k_cnt == '0);
      acc_last  = run && (k_cnt == K_LAST);
      done      = done_q;
   end

endmodule

// File: tb/tb_mat_addr_gen.sv
// Scoreboard bench for mat_addr_gen: a 2x2x2 instance for the detailed
// scenarios and a default 8x8x8 instance for the full-size sweep.
module tb_mat_addr_gen;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] c;
      logic        f;
      logic        l;
   } beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_run  = 0;
   int n_fail = 0;

   logic rst    = 1'b0;
   logic start2 = 1'b0, stall2 = 1'b0;
   logic start8 = 1'b0, stall8 = 1'b0;
`ifdef MAT_AGEN_TRANSPOSE_B_EN
   logic trans2 = 1'b0, trans8 = 1'b0;
`endif

   logic       busy2, valid2, f2, l2, done2;
   logic [1:0] a2, b2, c2;
   logic       busy8, valid8, f8, l8, done8;
   logic [5:0] a8, b8, c8;

   beat_t q2[$], q8[$];
   int    dq2[$], dq8[$];
   beat_t got2, got8;

   mat_addr_gen #(.M(2), .N(2), .K(2)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .stall(stall2),
`ifdef MAT_AGEN_TRANSPOSE_B_EN
      .trans_b(trans2),
`endif
      .busy(busy2), .valid(valid2), .addr_a(a2), .addr_b(b2), .addr_c(c2),
      .acc_first(f2), .acc_last(l2), .done(done2)
   );

   mat_addr_gen dut8 (
      .clk(clk), .rst(rst), .start(start8), .stall(stall8),
`ifdef MAT_AGEN_TRANSPOSE_B_EN
      .trans_b(trans8),
`endif
      .busy(busy8), .valid(valid8), .addr_a(a8), .addr_b(b8), .addr_c(c8),
      .acc_first(f8), .acc_last(l8), .done(done8)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_beat(input string pfx, input beat_t got, input beat_t exp);
      check_val({pfx, " addr_a"}, 32'(got.a), 32'(exp.a));
      check_val({pfx, " addr_b"}, 32'(got.b), 32'(exp.b));
      check_val({pfx, " addr_c"}, 32'(got.c), 32'(exp.c));
      check_val({pfx, " acc_first"}, 32'(got.f), 32'(exp.f));
      check_val({pfx, " acc_last"}, 32'(got.l), 32'(exp.l));
   endtask

   // Reference sweep from the closed-form address equations.
   task automatic push_sweep(input int sel, input int mm, input int nn, input int kk, input bit tr);
      beat_t e;
      for (int m = 0; m < mm; m++)
         for (int n = 0; n < nn; n++)
            for (int k = 0; k < kk; k++) begin
               e.a = 16'(m*kk + k);
               e.b = tr ? 16'(n*kk + k) : 16'(k*nn + n);
               e.c = 16'(m*nn + n);
               e.f = (k == 0);
               e.l = (k == kk - 1);
               if (sel == 2) q2.push_back(e);
               else          q8.push_back(e);
            end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input int sel, input int budget, input string tag);
      int left = budget;
      int pend;
      pend = (sel == 2) ? (q2.size() + dq2.size()) : (q8.size() + dq8.size());
      while (pend != 0 && left > 0) begin
         tick();
         left--;
         pend = (sel == 2) ? (q2.size() + dq2.size()) : (q8.size() + dq8.size());
      end
      check_val({tag, " pending"}, 32'(pend), 32'd0);
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) tick();
   endtask

   // Launch a 2x2x2 sweep; returns t, the cycle in which start was high.
   task automatic launch2(input bit tr, output int t);
`ifdef MAT_AGEN_TRANSPOSE_B_EN
      trans2 = tr;
`endif
      start2 = 1'b1;
      push_sweep(2, 2, 2, 2, tr);
      tick();
      t = cyc - 1;
      start2 = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (valid2) begin
            if (q2.size() == 0) begin
               check_val("dut2 extra beat", 32'd1, 32'd0);
            end else begin
               got2.a = 16'(a2); got2.b = 16'(b2); got2.c = 16'(c2);
               got2.f = f2;      got2.l = l2;
               check_beat("dut2", got2, q2[0]);
               if (!stall2) void'(q2.pop_front());
            end
         end
         check_val("dut2 busy", 32'(busy2), 32'(valid2));
         if (done2) begin
            check_val("dut2 valid in done", 32'(valid2), 32'd0);
            if (dq2.size() == 0) check_val("dut2 unexpected done", 32'd1, 32'd0);
            else                 check_val("dut2 done cycle", 32'(cyc), 32'(dq2.pop_front()));
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         if (valid8) begin
            if (q8.size() == 0) begin
               check_val("dut8 extra beat", 32'd1, 32'd0);
            end else begin
               got8.a = 16'(a8); got8.b = 16'(b8); got8.c = 16'(c8);
               got8.f = f8;      got8.l = l8;
               check_beat("dut8", got8, q8[0]);
               if (!stall8) void'(q8.pop_front());
            end
         end
         if (done8) begin
            check_val("dut8 valid in done", 32'(valid8), 32'd0);
            if (dq8.size() == 0) check_val("dut8 unexpected done", 32'd1, 32'd0);
            else                 check_val("dut8 done cycle", 32'(cyc), 32'(dq8.pop_front()));
         end
      end
   end

   initial begin
      int t0, t1;

      repeat (3) tick();
      rst = 1'b1;
      @(negedge clk);
      check_val("rst valid", 32'(valid2), 32'd0);
      check_val("rst busy", 32'(busy2), 32'd0);
      check_val("rst addr_a", 32'(a2), 32'd0);
      check_val("rst addr_b", 32'(b2), 32'd0);
      check_val("rst addr_c", 32'(c2), 32'd0);
      check_val("rst acc_first", 32'(f2), 32'd0);
      check_val("rst acc_last", 32'(l2), 32'd0);
      check_val("rst done", 32'(done2), 32'd0);
      check_val("rst valid8", 32'(valid8), 32'd0);
      tick();

      // Plain sweep; stall in IDLE must not matter.
      stall2 = 1'b1;
      tick();
      stall2 = 1'b0;
      launch2(1'b0, t0);
      dq2.push_back(t0 + 9);
      wait_drain(2, 40, "plain");

      // Three stall cycles on the beat (a=0, b=1, c=1).
      tick();
      launch2(1'b0, t0);
      dq2.push_back(t0 + 12);
      wait_cyc(t0 + 3);
      stall2 = 1'b1;
      @(negedge clk);
      check_val("stall beat a", 32'(a2), 32'd0);
      check_val("stall beat b", 32'(b2), 32'd1);
      check_val("stall beat c", 32'(c2), 32'd1);
      wait_cyc(t0 + 6);
      stall2 = 1'b0;
      wait_drain(2, 40, "stall");

      // Reset mid-sweep abandons it without a done pulse.
      tick();
      launch2(1'b0, t0);
      wait_cyc(t0 + 4);
      rst = 1'b0;
      q2.delete();
      dq2.delete();
      tick();
      rst = 1'b1;
      @(negedge clk);
      check_val("midrst valid", 32'(valid2), 32'd0);
      check_val("midrst addr_a", 32'(a2), 32'd0);
      check_val("midrst addr_b", 32'(b2), 32'd0);
      check_val("midrst addr_c", 32'(c2), 32'd0);
      check_val("midrst done", 32'(done2), 32'd0);
      repeat (12) tick();
      launch2(1'b0, t0);
      dq2.push_back(t0 + 9);
      wait_drain(2, 40, "after reset");

      // start during RUN is ignored; start in the done cycle restarts.
      tick();
      launch2(1'b0, t0);
      dq2.push_back(t0 + 9);
      wait_cyc(t0 + 3);
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      wait_cyc(t0 + 9);
      @(negedge clk);
      check_val("done cycle flag", 32'(done2), 32'd1);
      launch2(1'b0, t1);
      check_val("restart t", 32'(t1), 32'(t0 + 9));
      dq2.push_back(t1 + 9);
      @(negedge clk);
      check_val("restart valid", 32'(valid2), 32'd1);
      wait_drain(2, 40, "back to back");

`ifdef MAT_AGEN_TRANSPOSE_B_EN
      tick();
      launch2(1'b1, t0);
      dq2.push_back(t0 + 9);
      wait_drain(2, 40, "transpose");
      trans2 = 1'b0;
`endif

      // Full default-size sweep.
      tick();
      start8 = 1'b1;
      push_sweep(8, 8, 8, 8, 1'b0);
      tick();
      t0 = cyc - 1;
      start8 = 1'b0;
      dq8.push_back(t0 + 513);
      wait_drain(8, 700, "full 8x8x8");

      repeat (2) tick();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
